// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR-driven UART transmitter: frame FSM states,
// LFSR polynomial/width and the Galois step function.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 16'hB400;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Galois form: shift right and fold the polynomial in when the LSB falls out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a ready/valid byte input; ready also rises in the
// last stop-bit cycle so back-to-back bytes leave no idle gap on the line.
module uart_tx_byte
  import lfsr_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(FRAME_BITS - 3);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        last_tick;

  assign last_tick = (cnt_q == LAST_TICK);
  assign ready     = (state_q == IDLE) || ((state_q == STOP) && last_tick);
  assign done      = (state_q == STOP) && last_tick;
  assign tx        = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx is computed one cycle ahead so the line changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = last_tick ? '0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (valid) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last_tick) begin
          if (valid) begin
            state_d = START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lfsr_uart_tx.sv
// Advances a 16-bit Galois LFSR on each accepted trigger and sends the new
// value over UART as two 8N1 frames, low byte first.
module lfsr_uart_tx
  import lfsr_pkg::*;
#(
  parameter int                    CLKS_PER_BIT = 868,
  parameter logic [LFSR_WIDTH-1:0] SEED         = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  output logic                  tx,
  output logic                  busy,
  output logic [LFSR_WIDTH-1:0] lfsr_q,
  output logic                  drop
);

  // An all-zero state would lock the LFSR up forever.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_WIDTH-1:0] lfsr_reg;
  logic [LFSR_WIDTH-1:0] lfsr_nxt;
  logic                  busy_q;
  logic                  second_q;
  logic                  drop_q;
  logic                  accept;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  byte_done;

  assign lfsr_nxt   = lfsr_next(lfsr_reg);
  assign accept     = trigger && !busy_q;
  assign byte_valid = accept || (busy_q && !second_q);
  assign byte_data  = accept ? lfsr_nxt[7:0] : lfsr_reg[15:8];

  assign lfsr_q = lfsr_reg;
  assign busy   = busy_q;
  assign drop   = drop_q;

  // The high byte is offered for the whole first frame; the serializer takes
  // it in the last stop-bit cycle of the low byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED_EFF;
      busy_q   <= 1'b0;
      second_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= trigger && busy_q;
      if (accept) begin
        lfsr_reg <= lfsr_nxt;
        busy_q   <= 1'b1;
        second_q <= 1'b0;
      end else if (busy_q && !second_q && byte_ready) begin
        second_q <= 1'b1;
      end else if (busy_q && second_q && byte_done) begin
        busy_q   <= 1'b0;
        second_q <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .data (byte_data),
    .valid(byte_valid),
    .ready(byte_ready),
    .tx   (tx),
    .done (byte_done)
  );

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Directed bench for lfsr_uart_tx: default seed, zero seed and full-rate
// bit timing, each on its own instance driven from one linear sequence.
module tb_lfsr_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0, trig_z = 1'b0, trig_l = 1'b0;
  logic        tx, busy, drop;
  logic        tx_z, busy_z, drop_z;
  logic        tx_l, busy_l, drop_l;
  logic [15:0] lfsr_q, lfsr_z, lfsr_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .trigger(trig),
    .tx(tx), .busy(busy), .lfsr_q(lfsr_q), .drop(drop)
  );

  lfsr_uart_tx #(.CLKS_PER_BIT(4), .SEED(16'h0000)) dut_z (
    .clk(clk), .rst(rst), .trigger(trig_z),
    .tx(tx_z), .busy(busy_z), .lfsr_q(lfsr_z), .drop(drop_z)
  );

  lfsr_uart_tx #(.CLKS_PER_BIT(868)) dut_l (
    .clk(clk), .rst(rst), .trigger(trig_l),
    .tx(tx_l), .busy(busy_l), .lfsr_q(lfsr_l), .drop(drop_l)
  );

  // Expected line level c cycles into a two-byte transmission of word.
  function automatic logic frame_bit(input logic [15:0] word, input int c, input int cpb);
    int b, pos;
    b   = c / cpb;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return word[(b / 10) * 8 + pos - 1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle trigger pulse on the selected instance; returns in the cycle after acceptance.
  task automatic applyStimulus(input int which);
    if (which == 0) trig = 1'b1;
    else if (which == 1) trig_z = 1'b1;
    else trig_l = 1'b1;
    tick();
    trig = 1'b0; trig_z = 1'b0; trig_l = 1'b0;
  endtask

  initial begin
    $display("[TB] reset");
    repeat (3) tick();
    checkOutput("rst_state", {tx, busy, drop, lfsr_q}, {1'b1, 1'b0, 1'b0, 16'hACE1});
    checkOutput("rst_zero_seed", 32'(lfsr_z), 32'h0001);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      checkOutput("idle", {tx, busy, drop, lfsr_q}, {1'b1, 1'b0, 1'b0, 16'hACE1});
    end

    $display("[TB] single trigger");
    applyStimulus(0);
    checkOutput("first_lfsr", 32'(lfsr_q), 32'hE270);
    for (int c = 0; c < 80; c++) begin
      checkOutput("frame1", {busy, tx}, {1'b1, frame_bit(16'hE270, c, 4)});
      tick();
    end
    checkOutput("frame1_end", {busy, tx, lfsr_q}, {1'b0, 1'b1, 16'hE270});

    $display("[TB] triggers while busy");
    applyStimulus(0);
    for (int c = 0; c < 80; c++) begin
      checkOutput("drop_frame", {busy, tx, lfsr_q}, {1'b1, frame_bit(16'h7138, c, 4), 16'h7138});
      checkOutput("drop_pulse", 32'(drop), 32'((c == 2) || (c == 41)));
      trig = (c == 1) || (c == 40) || (c == 79);
      tick();
    end
    checkOutput("drop_last", {busy, drop, lfsr_q}, {1'b0, 1'b1, 16'h7138});
    trig = 1'b1;
    tick();
    trig = 1'b0;
    checkOutput("accept_after", {busy, drop, lfsr_q}, {1'b1, 1'b0, 16'h389C});
    for (int c = 0; c < 80; c++) begin
      checkOutput("frame3", {busy, drop, tx}, {1'b1, 1'b0, frame_bit(16'h389C, c, 4)});
      tick();
    end
    checkOutput("frame3_end", {busy, tx}, {1'b0, 1'b1});

    $display("[TB] reset mid-frame");
    applyStimulus(0);
    checkOutput("pre_rst_lfsr", 32'(lfsr_q), 32'h1C4E);
    for (int c = 0; c < 30; c++) tick();
    rst = 1'b1;
    trig = 1'b1;
    tick();
    rst = 1'b0;
    trig = 1'b0;
    checkOutput("rst_abort", {tx, busy, drop, lfsr_q}, {1'b1, 1'b0, 1'b0, 16'hACE1});
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("rst_idle", {tx, busy, drop, lfsr_q}, {1'b1, 1'b0, 1'b0, 16'hACE1});
    end
    applyStimulus(0);
    checkOutput("rst_restart", 32'(lfsr_q), 32'hE270);
    for (int c = 0; c < 80; c++) begin
      checkOutput("frame4", {busy, tx}, {1'b1, frame_bit(16'hE270, c, 4)});
      tick();
    end
    checkOutput("frame4_end", {busy, tx}, {1'b0, 1'b1});

    $display("[TB] zero seed");
    applyStimulus(1);
    checkOutput("zero_lfsr1", 32'(lfsr_z), 32'hB400);
    for (int c = 0; c < 99; c++) begin
      if (c < 80) checkOutput("zero_frame1", {busy_z, tx_z}, {1'b1, frame_bit(16'hB400, c, 4)});
      else checkOutput("zero_gap", {busy_z, tx_z}, {1'b0, 1'b1});
      tick();
    end
    applyStimulus(1);
    checkOutput("zero_lfsr2", 32'(lfsr_z), 32'h5A00);
    for (int c = 0; c < 80; c++) begin
      checkOutput("zero_frame2", {busy_z, tx_z}, {1'b1, frame_bit(16'h5A00, c, 4)});
      tick();
    end
    checkOutput("zero_end", {busy_z, tx_z}, {1'b0, 1'b1});

    $display("[TB] full-rate bit timing");
    applyStimulus(2);
    checkOutput("long_lfsr", 32'(lfsr_l), 32'hE270);
    for (int c = 0; c < 17360; c++) begin
      checkOutput("long_frame", {busy_l, tx_l}, {1'b1, frame_bit(16'hE270, c, 868)});
      tick();
    end
    checkOutput("long_end", {busy_l, tx_l}, {1'b0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_uart_tx.md
LFSR_UART_TX -- requirements
Module: lfsr_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter SEED, default 16'hACE1, meaning LFSR reset value; SEED=0 SHALL be replaced by 16'h0001.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 trigger  input  1  one-cycle request pulse from the upstream button debouncer, already synchronous to clk.
REQ-006 tx  output  1  UART serial line, 8N1, idles high.
REQ-007 busy  output  1  high while a two-byte transmission is in progress.
REQ-008 lfsr_q  output  16  current LFSR state, i.e. the value being or last transmitted.
REQ-009 drop  output  1  one-cycle pulse when a trigger is ignored.

Function
REQ-010 LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1: next = (q>>1) XOR (q[0] ? 16'hB400 : 0).
REQ-011 LFSR SHALL advance exactly once per accepted trigger and at no other time.
REQ-012 A trigger SHALL be accepted only when the FSM is in IDLE; acceptance occurs in the cycle trigger is high.
REQ-013 In the cycle after acceptance: lfsr_q shows the new value, busy=1, tx=0 (start bit of byte 0).
REQ-014 Byte 0 = lfsr_q[7:0], byte 1 = lfsr_q[15:8]; each frame = start(0), 8 data bits LSB first, stop(1).
REQ-015 Every bit SHALL last exactly CLKS_PER_BIT cycles; byte 1 start bit SHALL follow byte 0 stop bit with no idle gap.
REQ-016 Total busy time SHALL be exactly 20*CLKS_PER_BIT cycles; busy falls, and IDLE is entered, in the cycle after the last stop-bit cycle.
REQ-017 FSM states: IDLE -> START -> DATA (8 bits) -> STOP -> (byte 0 ? START of byte 1 : IDLE).
REQ-018 tx SHALL be high in IDLE and STOP, 0 in START, the current data bit in DATA.
REQ-019 A trigger arriving while busy=1, including the final stop-bit cycle, SHALL be ignored, leave LFSR unchanged, and pulse drop for one cycle, the cycle after the trigger.
REQ-020 A trigger in the first IDLE cycle after busy falls SHALL be accepted normally.
REQ-021 The bit counter SHALL be 16 bits wide and count 0..CLKS_PER_BIT-1, then wrap; no other wrap-around is permitted.
REQ-022 tx, busy and drop SHALL be registered outputs, glitch-free.

Reset
REQ-023 While rst=1: state=IDLE, tx=1, busy=0, drop=0, lfsr_q=SEED (or 16'h0001), counters=0.
REQ-024 rst asserted mid-frame SHALL abort the transmission within one cycle (tx=1 the cycle after rst is sampled); no partial-frame completion.
REQ-025 rst SHALL have priority over trigger in the same cycle; that trigger is neither accepted nor counted as a drop.

Structure
REQ-026 Shared package lfsr_pkg SHALL hold the FSM state enumeration, LFSR_POLY=16'hB400, LFSR_WIDTH=16, and FRAME_BITS=10.
REQ-027 Byte serialization SHALL be a sub-module uart_tx_byte (start/data/stop timing, ready/valid byte input, done pulse); lfsr_uart_tx holds the LFSR and two-byte sequencing.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-028 Reset release, no trigger for 100 cycles -> tx=1, busy=0, drop=0, lfsr_q=16'hACE1 throughout.
REQ-029 Single trigger -> next cycle lfsr_q=16'hE270, busy=1. tx sequence per 4 cycles: 0, 0,0,0,0,1,1,1,0, 1 (byte 0x70), then 0, 0,1,0,0,0,1,1,1, 1 (byte 0xE2). busy=1 for exactly 80 cycles.
REQ-030 SEED=0, two triggers spaced 100 cycles -> lfsr_q=16'hB400 then 16'h5A00; bytes on tx 0x00,0xB4 then 0x00,0x5A.
REQ-031 Trigger at busy cycles 1, 40 and 79 -> three drop pulses, lfsr_q unchanged, frame timing unaltered. Trigger in first cycle with busy=0 -> accepted.
REQ-032 rst pulsed at cycle 30 of a transmission -> tx=1, busy=0 next cycle, lfsr_q=SEED. Subsequent trigger -> lfsr_q=16'hE270 and a full 80-cycle transmission.
REQ-033 CLKS_PER_BIT=868, one trigger -> each bit width measured at exactly 868 cycles, busy high for 17360 cycles.
